// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the PLL-lock-qualified reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int CLK_HZ  = 81_000_000;
    localparam int LOCK_US = 100;

    // Lock qualification time in clk cycles for the default clock and hold time.
    localparam int DEF_LOCK_CYCLES = (CLK_HZ / 1_000_000) * LOCK_US;

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// N-stage bit synchronizer with asynchronous active-low reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Holds domain resets until PLL lock is stable, then releases mem -> core -> bus in order.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       ext_rst_req,
    output logic       rst_mem_n,
    output logic       rst_core_n,
    output logic       rst_bus_n,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [1:0] state
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam int SCW = $clog2(2 * STAGE_GAP + 1);

    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);
    localparam logic [SCW-1:0] GAP1     = SCW'(STAGE_GAP);
    localparam logic [SCW-1:0] GAP2     = SCW'(2 * STAGE_GAP);

    logic lock_s;
    logic req_s;
    logic abort;

    seq_state_t     state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic [SCW-1:0] stage_cnt_q, stage_cnt_d;
    logic [7:0]     relock_d;
    logic           mem_d, core_d, bus_d, ready_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_rst_req),
        .q     (req_s)
    );

    assign abort = !lock_s || req_s;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        stage_cnt_d = stage_cnt_q;
        relock_d    = relock_cnt;
        mem_d       = rst_mem_n;
        core_d      = rst_core_n;
        bus_d       = rst_bus_n;
        ready_d     = ready;

        if (abort) begin
            state_d     = WAIT_LOCK;
            lock_cnt_d  = '0;
            stage_cnt_d = '0;
            mem_d       = 1'b0;
            core_d      = 1'b0;
            bus_d       = 1'b0;
            ready_d     = 1'b0;
            // Only a genuine lock loss out of a qualifying state is a relock event.
            if (!req_s && (state_q != WAIT_LOCK) && (relock_cnt != 8'hFF)) begin
                relock_d = relock_cnt + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d    = STABLE;
                    lock_cnt_d = LCW'(1);
                end
                STABLE: begin
                    if (lock_cnt_q == LOCK_MAX) begin
                        state_d     = RELEASE;
                        mem_d       = 1'b1;
                        stage_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    stage_cnt_d = stage_cnt_q + 1'b1;
                    if (stage_cnt_d == GAP1) begin
                        core_d = 1'b1;
                    end
                    if (stage_cnt_d == GAP2) begin
                        bus_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            lock_cnt_q  <= '0;
            stage_cnt_q <= '0;
            relock_cnt  <= '0;
            rst_mem_n   <= 1'b0;
            rst_core_n  <= 1'b0;
            rst_bus_n   <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            relock_cnt  <= relock_d;
            rst_mem_n   <= mem_d;
            rst_core_n  <= core_d;
            rst_bus_n   <= bus_d;
            ready       <= ready_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with LOCK_CYCLES=10, STAGE_GAP=4, SYNC_STAGES=2.
module tb_pll_reset_seq;

    localparam int LC = 10;
    localparam int SG = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       ext_rst_req = 1'b0;
    logic       rst_mem_n, rst_core_n, rst_bus_n, ready;
    logic [7:0] relock_cnt;
    logic [1:0] state;
    logic [13:0] obs;

    typedef struct {
        int          cyc;
        logic [13:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    pll_reset_seq #(
        .LOCK_CYCLES (LC),
        .STAGE_GAP   (SG),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .ext_rst_req (ext_rst_req),
        .rst_mem_n   (rst_mem_n),
        .rst_core_n  (rst_core_n),
        .rst_bus_n   (rst_bus_n),
        .ready       (ready),
        .relock_cnt  (relock_cnt),
        .state       (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {rst_mem_n, rst_core_n, rst_bus_n, ready, state, relock_cnt};

    // Expected output word: {mem, core, bus, ready, state[1:0], relock_cnt[7:0]}.
    function automatic logic [13:0] ev(logic m, logic c, logic b, logic r,
                                       logic [1:0] st, logic [7:0] rc);
        return {m, c, b, r, st, rc};
    endfunction

    function automatic void push(int c, logic [13:0] v, string tag);
        sb.push_back('{cyc: c, val: v, tag: tag});
    endfunction

    task automatic test_reset();
        int k, budget;
        exp_t e;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 2'd0, 8'd0)) begin
            n_err++;
            $display("FAIL reset_hold got=%h want=%h", obs, ev(0, 0, 0, 0, 2'd0, 8'd0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = cyc;
        for (int i = 1; i <= 50; i += 7) push(k + i, ev(0, 0, 0, 0, 2'd0, 8'd0), "no_lock");
        push(k + 50, ev(0, 0, 0, 0, 2'd0, 8'd0), "no_lock_end");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL reset_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_clean_lock();
        int k, budget;
        exp_t e;
        pll_lock = 1'b1;
        k = cyc;
        push(k + 2,  ev(0, 0, 0, 0, 2'd0, 8'd0), "cl_wait");
        push(k + 3,  ev(0, 0, 0, 0, 2'd1, 8'd0), "cl_stable");
        push(k + 12, ev(0, 0, 0, 0, 2'd1, 8'd0), "cl_mem_pre");
        push(k + 13, ev(1, 0, 0, 0, 2'd2, 8'd0), "cl_mem");
        push(k + 16, ev(1, 0, 0, 0, 2'd2, 8'd0), "cl_core_pre");
        push(k + 17, ev(1, 1, 0, 0, 2'd2, 8'd0), "cl_core");
        push(k + 20, ev(1, 1, 0, 0, 2'd2, 8'd0), "cl_bus_pre");
        push(k + 21, ev(1, 1, 1, 1, 2'd3, 8'd0), "cl_bus");
        push(k + 30, ev(1, 1, 1, 1, 2'd3, 8'd0), "cl_run_hold");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL clean_lock_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_glitch();
        int k, budget;
        exp_t e;
        pll_lock = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pll_lock = 1'b1;
        k = cyc;
        push(k + 3,  ev(0, 0, 0, 0, 2'd1, 8'd0), "gl_stable");
        push(k + 7,  ev(0, 0, 0, 0, 2'd1, 8'd0), "gl_pre_abort");
        push(k + 8,  ev(0, 0, 0, 0, 2'd0, 8'd1), "gl_abort");
        push(k + 13, ev(0, 0, 0, 0, 2'd1, 8'd1), "gl_no_release");
        push(k + 18, ev(0, 0, 0, 0, 2'd1, 8'd1), "gl_requal_pre");
        push(k + 19, ev(1, 0, 0, 0, 2'd2, 8'd1), "gl_mem");
        push(k + 27, ev(1, 1, 1, 1, 2'd3, 8'd1), "gl_run");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (cyc == k + 5) pll_lock = 1'b0;
            if (cyc == k + 6) pll_lock = 1'b1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL glitch_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_lock_loss_run();
        int k, budget;
        exp_t e;
        pll_lock = 1'b0;
        k = cyc;
        push(k + 2,  ev(1, 1, 1, 1, 2'd3, 8'd1), "ll_still_run");
        push(k + 3,  ev(0, 0, 0, 0, 2'd0, 8'd2), "ll_abort");
        push(k + 7,  ev(0, 0, 0, 0, 2'd0, 8'd2), "ll_wait");
        push(k + 8,  ev(0, 0, 0, 0, 2'd1, 8'd2), "ll_stable");
        push(k + 17, ev(0, 0, 0, 0, 2'd1, 8'd2), "ll_mem_pre");
        push(k + 18, ev(1, 0, 0, 0, 2'd2, 8'd2), "ll_mem");
        push(k + 21, ev(1, 0, 0, 0, 2'd2, 8'd2), "ll_core_pre");
        push(k + 22, ev(1, 1, 0, 0, 2'd2, 8'd2), "ll_core");
        push(k + 25, ev(1, 1, 0, 0, 2'd2, 8'd2), "ll_bus_pre");
        push(k + 26, ev(1, 1, 1, 1, 2'd3, 8'd2), "ll_bus");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (cyc == k + 5) pll_lock = 1'b1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL lock_loss_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_soft_reset();
        int k, budget;
        exp_t e;
        ext_rst_req = 1'b1;
        k = cyc;
        push(k + 2,  ev(1, 1, 1, 1, 2'd3, 8'd2), "sr_still_run");
        push(k + 3,  ev(0, 0, 0, 0, 2'd0, 8'd2), "sr_abort");
        push(k + 5,  ev(0, 0, 0, 0, 2'd0, 8'd2), "sr_hold");
        push(k + 6,  ev(0, 0, 0, 0, 2'd1, 8'd2), "sr_stable");
        push(k + 15, ev(0, 0, 0, 0, 2'd1, 8'd2), "sr_mem_pre");
        push(k + 16, ev(1, 0, 0, 0, 2'd2, 8'd2), "sr_mem");
        push(k + 20, ev(1, 1, 0, 0, 2'd2, 8'd2), "sr_core");
        push(k + 24, ev(1, 1, 1, 1, 2'd3, 8'd2), "sr_bus");
        // Request and lock loss together from RUN: no relock event.
        push(k + 33, ev(0, 0, 0, 0, 2'd0, 8'd2), "sr_both_abort");
        push(k + 38, ev(0, 0, 0, 0, 2'd1, 8'd2), "sr_both_stable");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (cyc == k + 3) ext_rst_req = 1'b0;
            if (cyc == k + 30) begin
                ext_rst_req = 1'b1;
                pll_lock    = 1'b0;
            end
            if (cyc == k + 35) begin
                ext_rst_req = 1'b0;
                pll_lock    = 1'b1;
            end
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL soft_reset_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_saturation_async();
        int k, budget;
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (5) @(negedge clk);
            pll_lock = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 251) begin
                n_cmp++;
                if (relock_cnt !== 8'd254) begin
                    n_err++;
                    $display("FAIL sat_254 got=%0d want=254", relock_cnt);
                end
            end
            if (i == 252) begin
                n_cmp++;
                if (relock_cnt !== 8'd255) begin
                    n_err++;
                    $display("FAIL sat_255 got=%0d want=255", relock_cnt);
                end
            end
        end
        pll_lock = 1'b1;
        k = cyc;
        push(k + 1,  ev(0, 0, 0, 0, 2'd0, 8'd255), "sat_hold");
        push(k + 13, ev(1, 0, 0, 0, 2'd2, 8'd255), "sat_mem");
        push(k + 14, ev(1, 0, 0, 0, 2'd2, 8'd255), "sat_release");
        budget = 200;
        while (sb.size() != 0) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, obs, e.val);
                end
            end
            budget--;
            if (budget == 0) begin
                n_err++;
                $display("FAIL saturation_timeout pending=%0d want=0", sb.size());
                sb.delete();
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ev(0, 0, 0, 0, 2'd0, 8'd0)) begin
            n_err++;
            $display("FAIL async_reset got=%h want=%h", obs, ev(0, 0, 0, 0, 2'd0, 8'd0));
        end
        #1 rst_n = 1'b1;
        pll_lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_lock_loss_run();
        test_soft_reset();
        test_saturation_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
